// File: rtl/wino_pkg.sv
// Shared types and constants for the streaming Winograd F(2,3) core.
// The optional WINO_SAT_EN build macro is consumed by wino_f23_stream.
package wino_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_DIN   = 3'd2,
        S_MAC   = 3'd3,
        S_OUT   = 3'd4
    } wino_state_e;

    // Filter transform is stored scaled by 2 so u1/u2 need no halving; edges are doubled by shift.
    localparam int U_EDGE_SHIFT = 1;

    function automatic int acc_w(input int dw, input int ch);
        return 2 * dw + 3 + $clog2(ch + 1);
    endfunction

endpackage

// File: rtl/wino_f23_xform.sv
// Winograd F(2,3) data transform plus the four element-wise products m_i = u_i * v_i.
// Combinational; products are sign-extended to the accumulator width.
module wino_f23_xform
    import wino_pkg::*;
#(
    parameter int DW    = 10,
    parameter int ACC_W = 2 * DW + 4
) (
    input  logic signed [DW-1:0]    d0,
    input  logic signed [DW-1:0]    d1,
    input  logic signed [DW-1:0]    d2,
    input  logic signed [DW-1:0]    d3,
    input  logic signed [DW+1:0]    u0,
    input  logic signed [DW+1:0]    u1,
    input  logic signed [DW+1:0]    u2,
    input  logic signed [DW+1:0]    u3,
    output logic signed [ACC_W-1:0] m0,
    output logic signed [ACC_W-1:0] m1,
    output logic signed [ACC_W-1:0] m2,
    output logic signed [ACC_W-1:0] m3
);

    localparam int VW = DW + 1;
    localparam int PW = 2 * DW + 3;

    logic signed [VW-1:0] v0, v1, v2, v3;
    logic signed [PW-1:0] p0, p1, p2, p3;

    assign v0 = VW'(d0) - VW'(d2);
    assign v1 = VW'(d1) + VW'(d2);
    assign v2 = VW'(d2) - VW'(d1);
    assign v3 = VW'(d1) - VW'(d3);

    assign p0 = PW'(u0) * PW'(v0);
    assign p1 = PW'(u1) * PW'(v1);
    assign p2 = PW'(u2) * PW'(v2);
    assign p3 = PW'(u3) * PW'(v3);

    assign m0 = ACC_W'(p0);
    assign m1 = ACC_W'(p1);
    assign m2 = ACC_W'(p2);
    assign m3 = ACC_W'(p3);

endmodule

// File: rtl/wino_f23_stream.sv
// Streaming Winograd F(2,3) core: filter/tile loader, CH-channel accumulation, 2-word output port.
// Define WINO_SAT_EN to clamp outputs to the DW range instead of wrapping.
module wino_f23_stream
    import wino_pkg::*;
#(
    parameter int DW = 10,
    parameter int CH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_wload,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 busy
);

    localparam int ACC_W = acc_w(DW, CH);
    localparam int UW    = DW + 2;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    wino_state_e          state;
    logic signed [DW-1:0] g0, g1;
    logic signed [UW-1:0] u_mem [CH][4];
    logic signed [DW-1:0] d_mem [4];
    logic [1:0]           tap_cnt;
    logic [1:0]           beat_cnt;
    logic [CW-1:0]        ch_cnt;
    logic                 out_sel;
    logic signed [DW-1:0] y1;
    logic signed [ACC_W-1:0] acc0, acc1, acc0_nxt, acc1_nxt;
    logic signed [ACC_W-1:0] m0, m1, m2, m3;
    logic                 accept;

    function automatic logic signed [DW-1:0] to_out(input logic signed [ACC_W-1:0] y);
`ifdef WINO_SAT_EN
        if (y > Y_MAX) begin
            return Y_MAX[DW-1:0];
        end else if (y < Y_MIN) begin
            return Y_MIN[DW-1:0];
        end else begin
            return y[DW-1:0];
        end
`else
        return y[DW-1:0];
`endif
    endfunction

    assign accept = in_valid && in_ready;

    wino_f23_xform #(.DW(DW), .ACC_W(ACC_W)) u_xform (
        .d0(d_mem[0]), .d1(d_mem[1]), .d2(d_mem[2]), .d3(d_mem[3]),
        .u0(u_mem[ch_cnt][0]), .u1(u_mem[ch_cnt][1]),
        .u2(u_mem[ch_cnt][2]), .u3(u_mem[ch_cnt][3]),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3)
    );

    // Channel-0 MAC starts from zero; later channels add onto the running sums.
    always_comb begin
        acc0_nxt = m0 + m1 + m2;
        acc1_nxt = m1 - m2 - m3;
        if (ch_cnt != '0) begin
            acc0_nxt = acc0_nxt + acc0;
            acc1_nxt = acc1_nxt + acc1;
        end else begin
            acc0_nxt = acc0_nxt;
            acc1_nxt = acc1_nxt;
        end
    end

    // Main FSM with registered handshake outputs, filter store, tile capture and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            g0        <= '0;
            g1        <= '0;
            tap_cnt   <= 2'd0;
            beat_cnt  <= 2'd0;
            ch_cnt    <= '0;
            out_sel   <= 1'b0;
            y1        <= '0;
            acc0      <= '0;
            acc1      <= '0;
            for (int i = 0; i < 4; i++) d_mem[i] <= '0;
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < 4; j++) u_mem[c][j] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (in_wload) begin
                            g0      <= in_data;
                            tap_cnt <= 2'd1;
                            state   <= S_WLOAD;
                        end else begin
                            d_mem[0] <= in_data;
                            beat_cnt <= 2'd1;
                            state    <= S_DIN;
                        end
                    end
                end
                S_WLOAD: begin
                    if (accept) begin
                        case (tap_cnt)
                            2'd0: begin
                                g0      <= in_data;
                                tap_cnt <= 2'd1;
                            end
                            2'd1: begin
                                g1      <= in_data;
                                tap_cnt <= 2'd2;
                            end
                            default: begin
                                u_mem[ch_cnt][0] <= UW'(g0) <<< U_EDGE_SHIFT;
                                u_mem[ch_cnt][1] <= UW'(g0) + UW'(g1) + UW'(in_data);
                                u_mem[ch_cnt][2] <= UW'(g0) - UW'(g1) + UW'(in_data);
                                u_mem[ch_cnt][3] <= UW'(in_data) <<< U_EDGE_SHIFT;
                                tap_cnt          <= 2'd0;
                                if (ch_cnt == LAST_CH) begin
                                    ch_cnt <= '0;
                                    busy   <= 1'b0;
                                    state  <= S_IDLE;
                                end else begin
                                    ch_cnt <= ch_cnt + CW'(1);
                                end
                            end
                        endcase
                    end
                end
                S_DIN: begin
                    if (accept) begin
                        d_mem[beat_cnt] <= in_data;
                        beat_cnt        <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            in_ready <= 1'b0;
                            state    <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    acc0 <= acc0_nxt;
                    acc1 <= acc1_nxt;
                    if (ch_cnt == LAST_CH) begin
                        ch_cnt    <= '0;
                        out_data  <= to_out(acc0_nxt >>> 1);
                        y1        <= to_out(acc1_nxt >>> 1);
                        out_valid <= 1'b1;
                        out_sel   <= 1'b0;
                        state     <= S_OUT;
                    end else begin
                        ch_cnt   <= ch_cnt + CW'(1);
                        in_ready <= 1'b1;
                        state    <= S_DIN;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (!out_sel) begin
                            out_data <= y1;
                            out_sel  <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            out_sel   <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wino_f23_stream.sv
// Directed scoreboard bench for wino_f23_stream: a CH=1 and a CH=2 instance share one stimulus bus.
module tb_wino_f23_stream;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic in_valid;
    logic in_wload;
    logic signed [9:0] in_data;
    logic out_ready;

    logic v1, r1, ov1, or1, b1;
    logic v2, r2, ov2, or2, b2;
    logic signed [9:0] od1, od2;

    logic cur_ready, cur_ovalid, cur_busy;
    logic signed [9:0] cur_odata;

    logic signed [9:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign v1  = in_valid & ~sel;
    assign v2  = in_valid & sel;
    assign or1 = out_ready & ~sel;
    assign or2 = out_ready & sel;
    assign cur_ready  = sel ? r2 : r1;
    assign cur_ovalid = sel ? ov2 : ov1;
    assign cur_busy   = sel ? b2 : b1;
    assign cur_odata  = sel ? od2 : od1;

    wino_f23_stream #(.DW(10), .CH(1)) dut (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_wload(in_wload),
        .in_data(in_data), .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(b1)
    );

    wino_f23_stream #(.DW(10), .CH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_wload(in_wload),
        .in_data(in_data), .out_valid(ov2), .out_ready(or2), .out_data(od2), .busy(b2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send(input logic signed [9:0] w, input logic wl);
        int n;
        n = 0;
        in_data  = w;
        in_wload = wl;
        in_valid = 1'b1;
        while (cur_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 32'(n < 100), 32'sd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic filt(input logic signed [9:0] a, input logic signed [9:0] b, input logic signed [9:0] c);
        send(a, 1'b1);
        send(b, 1'b0);
        send(c, 1'b0);
    endtask

    task automatic tile(input logic signed [9:0] a, input logic signed [9:0] b,
                        input logic signed [9:0] c, input logic signed [9:0] d,
                        input logic signed [9:0] e0, input logic signed [9:0] e1);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
    endtask

    task automatic collect(input int stall, input int lat);
        logic signed [9:0] e;
        int n;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (cur_ovalid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("out_timeout", 32'(n < 50), 32'sd1);
            if (k == 0 && lat >= 0) chk("latency", 32'(n), 32'(lat));
            e = exp_q.pop_front();
            if (k == 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_hold", 32'(cur_odata), 32'(e));
                    chk("stall_in_ready", 32'(cur_ready), 32'sd0);
                    chk("stall_valid", 32'(cur_ovalid), 32'sd1);
                    @(negedge clk);
                end
            end
            chk(k == 0 ? "y0" : "y1", 32'(cur_odata), 32'(e));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("done_valid", 32'(cur_ovalid), 32'sd0);
        chk("done_busy", 32'(cur_busy), 32'sd0);
        chk("done_ready", 32'(cur_ready), 32'sd1);
    endtask

    initial begin
        logic signed [9:0] sat_exp;
`ifdef WINO_SAT_EN
        sat_exp = 10'sd511;
`else
        sat_exp = 10'sd3;
`endif
        sel = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_wload = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_in_ready", 32'(cur_ready), 32'sd1);
        chk("rst_out_valid", 32'(cur_ovalid), 32'sd0);
        chk("rst_out_data", 32'(cur_odata), 32'sd0);
        chk("rst_busy", 32'(cur_busy), 32'sd0);

        filt(10'sd1, 10'sd1, 10'sd1);
        chk("wload_idle_busy", 32'(cur_busy), 32'sd0);
        tile(10'sd1, 10'sd2, 10'sd3, 10'sd4, 10'sd6, 10'sd9);
        chk("mac_in_ready", 32'(cur_ready), 32'sd0);
        chk("mac_busy", 32'(cur_busy), 32'sd1);
        collect(0, 1);

        filt(10'sd1, -10'sd2, 10'sd1);
        tile(10'sd5, 10'sd3, 10'sd7, 10'sd2, 10'sd6, -10'sd9);
        collect(0, 1);

        // Filter persists; downstream stalls 5 cycles on y0.
        tile(10'sd5, 10'sd3, 10'sd7, 10'sd2, 10'sd6, -10'sd9);
        collect(5, 1);

        filt(10'sd511, 10'sd511, 10'sd511);
        tile(10'sd511, 10'sd511, 10'sd511, 10'sd511, sat_exp, sat_exp);
        collect(0, 1);

        // Abort mid-tile; filters are wiped so the next tile yields zeros.
        send(10'sd7, 1'b0);
        send(10'sd9, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(cur_ready), 32'sd1);
        chk("abort_busy", 32'(cur_busy), 32'sd0);
        chk("abort_out_valid", 32'(cur_ovalid), 32'sd0);
        tile(10'sd1, 10'sd2, 10'sd3, 10'sd4, 10'sd0, 10'sd0);
        collect(0, 1);

        sel = 1'b1;
        @(negedge clk);
        send(10'sd1, 1'b1);
        send(10'sd1, 1'b0);
        send(10'sd1, 1'b0);
        send(10'sd2, 1'b0);
        send(10'sd0, 1'b0);
        send(10'sd0, 1'b0);
        chk("ch2_wload_done", 32'(cur_busy), 32'sd0);
        send(10'sd1, 1'b0);
        send(10'sd2, 1'b0);
        send(10'sd3, 1'b0);
        send(10'sd4, 1'b0);
        tile(10'sd1, 10'sd1, 10'sd1, 10'sd1, 10'sd8, 10'sd11);
        collect(0, 1);

        chk("queue_empty", 32'(exp_q.size()), 32'sd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
